// File: rtl/traffic_timer_if.sv
// Handshake bundle between the traffic-light controller (master) and traffic_timer (slave).
// With TIMER_DISPLAY_EN defined the bundle also carries the remaining-seconds display value.
interface traffic_timer_if;
  logic       start_timer;
  logic [1:0] interval;
  logic       prog;
  logic [1:0] time_param_sel;
  logic [3:0] time_value;
  logic       expired;
`ifdef TIMER_DISPLAY_EN
  logic [3:0] count_out;

  modport master (
    output start_timer, interval, prog, time_param_sel, time_value,
    input  expired, count_out
  );

  modport slave (
    input  start_timer, interval, prog, time_param_sel, time_value,
    output expired, count_out
  );
`else
  modport master (
    output start_timer, interval, prog, time_param_sel, time_value,
    input  expired
  );

  modport slave (
    input  start_timer, interval, prog, time_param_sel, time_value,
    output expired
  );
`endif
endinterface

// File: rtl/traffic_timer.sv
// Programmable seconds countdown for the traffic-light controller, clocked from a 1 Hz divider.
// Optional macro TIMER_DISPLAY_EN adds a registered count_out for a hex display.
module traffic_timer #(
  parameter int CLKS_PER_SEC = 27000000,
  parameter int DIV_W        = 25,
  parameter int T_BASE_DEF   = 6,
  parameter int T_EXT_DEF    = 3,
  parameter int T_YEL_DEF    = 2
) (
  input  logic            clk,
  input  logic            rst,
  traffic_timer_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic [3:0]         count_q, count_d;
  logic [3:0]         t_base_q, t_base_d;
  logic [3:0]         t_ext_q, t_ext_d;
  logic [3:0]         t_yel_q, t_yel_d;
  logic               expired_q, expired_d;
  logic               autostart_q, autostart_d;
  logic               tick_s;
  logic [1:0]         start_sel_s;
  logic [3:0]         start_val_s;

  assign tick_s = (state_q == RUN) && (div_q == DIV_W'(CLKS_PER_SEC - 1));

  // Interval lookup for a start; the post-reset auto-start uses the extended interval.
  always_comb begin
    start_sel_s = bus.start_timer ? bus.interval : 2'b01;
    case (start_sel_s)
      2'b00:   start_val_s = t_base_q;
      2'b01:   start_val_s = t_ext_q;
      2'b10:   start_val_s = t_yel_q;
      default: start_val_s = t_base_q;
    endcase
  end

  // Next-state logic; priority is prog, then start/auto-start, then the running countdown.
  always_comb begin
    state_d     = state_q;
    div_d       = div_q;
    count_d     = count_q;
    t_base_d    = t_base_q;
    t_ext_d     = t_ext_q;
    t_yel_d     = t_yel_q;
    expired_d   = 1'b0;
    autostart_d = 1'b0;

    if (bus.prog) begin
      case (bus.time_param_sel)
        2'b00:   t_base_d = bus.time_value;
        2'b01:   t_ext_d  = bus.time_value;
        2'b10:   t_yel_d  = bus.time_value;
        default: t_base_d = t_base_q;
      endcase
      // Restart reads the freshly written extended value when this write targeted it.
      count_d = t_ext_d;
      div_d   = '0;
      state_d = RUN;
    end else if (bus.start_timer || autostart_q) begin
      count_d = start_val_s;
      div_d   = '0;
      state_d = RUN;
    end else if (state_q == RUN) begin
      if (tick_s) begin
        div_d = '0;
        if (count_q <= 4'd1) begin
          expired_d = 1'b1;
          state_d   = IDLE;
        end else begin
          count_d = count_q - 4'd1;
        end
      end else begin
        div_d = div_q + DIV_W'(1);
      end
    end else begin
      div_d = '0;
    end
  end

  // State and parameter registers; reset arms the auto-start for the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      div_q       <= '0;
      count_q     <= 4'd0;
      t_base_q    <= 4'(T_BASE_DEF);
      t_ext_q     <= 4'(T_EXT_DEF);
      t_yel_q     <= 4'(T_YEL_DEF);
      expired_q   <= 1'b0;
      autostart_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      div_q       <= div_d;
      count_q     <= count_d;
      t_base_q    <= t_base_d;
      t_ext_q     <= t_ext_d;
      t_yel_q     <= t_yel_d;
      expired_q   <= expired_d;
      autostart_q <= autostart_d;
    end
  end

  assign bus.expired = expired_q;

`ifdef TIMER_DISPLAY_EN
  logic [3:0] count_out_q;

  // Display copy of the count, forced to zero whenever the timer is idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_out_q <= 4'd0;
    end else begin
      count_out_q <= (state_d == RUN) ? count_d : 4'd0;
    end
  end

  assign bus.count_out = count_out_q;
`endif

endmodule

// File: tb/tb_traffic_timer.sv
// Directed bench for traffic_timer with CLKS_PER_SEC=4: table of start/prog vectors plus
// hand-written reset, mid-run restart and tick-collision sequences.
module tb_traffic_timer;

  localparam int CPS = 4;

  logic clk;
  logic rst;
  int   n_pass;
  int   n_total;

  traffic_timer_if bus ();

  traffic_timer #(
    .CLKS_PER_SEC(CPS),
    .DIV_W       (3),
    .T_BASE_DEF  (6),
    .T_EXT_DEF   (3),
    .T_YEL_DEF   (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       start;
    logic [1:0] iv;
    logic       prog;
    logic [1:0] sel;
    logic [3:0] val;
    int         lat;
  } vec_t;

  vec_t vecs [14];

  task automatic check_int(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Called at a negedge; holds the inputs across one posedge, returns at the next negedge.
  task automatic drive(input logic s, input logic [1:0] iv, input logic p,
                       input logic [1:0] sel, input logic [3:0] val);
    bus.start_timer    = s;
    bus.interval       = iv;
    bus.prog           = p;
    bus.time_param_sel = sel;
    bus.time_value     = val;
    @(negedge clk);
    bus.start_timer    = 1'b0;
    bus.prog           = 1'b0;
  endtask

  // k = posedges since the load edge; returns at the negedge where expired is seen.
  task automatic measure(output int lat);
    lat = -1;
    for (int k = 0; k <= 200; k++) begin
      if (bus.expired === 1'b1) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_and_check(input string name, input int exp_lat);
    int lat;
    measure(lat);
    check_int({name, "_latency"}, lat, exp_lat);
    @(negedge clk);
    check_int({name, "_width"}, int'(bus.expired), 0);
  endtask

  task automatic quiet(input string name, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      if (bus.expired !== 1'b0) seen++;
      @(negedge clk);
    end
    check_int({name, "_quiet"}, seen, 0);
  endtask

  task automatic do_reset(input string name);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_int({name, "_expired_in_reset"}, int'(bus.expired), 0);
    rst = 1'b0;
    @(negedge clk);
    run_and_check({name, "_autostart"}, 3 * CPS);
  endtask

  initial begin
    n_pass = 0;
    n_total = 0;
    rst = 1'b1;
    bus.start_timer    = 1'b0;
    bus.interval       = 2'b00;
    bus.prog           = 1'b0;
    bus.time_param_sel = 2'b00;
    bus.time_value     = 4'd0;

    vecs[0]  = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0,  6 * CPS};
    vecs[1]  = '{1'b1, 2'b10, 1'b0, 2'b00, 4'd0,  2 * CPS};
    vecs[2]  = '{1'b1, 2'b11, 1'b0, 2'b00, 4'd0,  6 * CPS};
    vecs[3]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0,  3 * CPS};
    vecs[4]  = '{1'b0, 2'b00, 1'b1, 2'b10, 4'd5,  3 * CPS};
    vecs[5]  = '{1'b1, 2'b10, 1'b0, 2'b00, 4'd0,  5 * CPS};
    vecs[6]  = '{1'b0, 2'b00, 1'b1, 2'b01, 4'd0,  1 * CPS};
    vecs[7]  = '{1'b1, 2'b01, 1'b0, 2'b00, 4'd0,  1 * CPS};
    vecs[8]  = '{1'b0, 2'b00, 1'b1, 2'b11, 4'd9,  1 * CPS};
    vecs[9]  = '{1'b1, 2'b00, 1'b1, 2'b01, 4'd2,  2 * CPS};
    vecs[10] = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0,  6 * CPS};
    vecs[11] = '{1'b0, 2'b00, 1'b1, 2'b00, 4'd1,  2 * CPS};
    vecs[12] = '{1'b1, 2'b00, 1'b0, 2'b00, 4'd0,  1 * CPS};
    vecs[13] = '{1'b0, 2'b00, 1'b1, 2'b01, 4'd15, 15 * CPS};

    @(negedge clk);
    do_reset("por");
    quiet("idle_after_por", 6);

    for (int i = 0; i < 14; i++) begin
      drive(vecs[i].start, vecs[i].iv, vecs[i].prog, vecs[i].sel, vecs[i].val);
      run_and_check($sformatf("vec%0d", i), vecs[i].lat);
    end

    // Reset in the middle of a 60-cycle extended run: no pulse, defaults come back.
    drive(1'b1, 2'b01, 1'b0, 2'b00, 4'd0);
    quiet("pre_rst_run", 3);
    do_reset("mid_rst");
    drive(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    run_and_check("base_default", 6 * CPS);

    // Restart a base run at cycle 10 with the yellow interval.
    drive(1'b1, 2'b00, 1'b0, 2'b00, 4'd0);
    quiet("base_before_restart", 10);
    drive(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    run_and_check("mid_restart", 2 * CPS);
    quiet("old_run_discarded", 20);

    // Start colliding with the final tick of a 1 s run: reload wins, no pulse on that tick.
    drive(1'b0, 2'b00, 1'b1, 2'b10, 4'd1);
    run_and_check("prog_yel1", 3 * CPS);
    drive(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    quiet("tick_pre", CPS - 1);
    drive(1'b1, 2'b10, 1'b0, 2'b00, 4'd0);
    run_and_check("tick_vs_start", 1 * CPS);
    quiet("final_idle", 10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
